// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths and owner codes for the RAM arbiter slice
package ram_arbiter_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_LDR  = 2'd2
  } owner_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU, loader and RAM-macro signals; slave is the arbiter view
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic [1:0]        owner;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ram_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output ram_we, ram_addr, ram_din, owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ram_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  ram_we, ram_addr, ram_din, owner
  );
endinterface

// File: rtl/ram_arb_starve_cnt.sv
// ram_arb_starve_cnt: saturating count of cycles a requester waited; flags force once MAX_WAIT reached
module ram_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_force
);
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  always_comb begin
    w_cnt_nxt = (!i_req || i_gnt) ? 4'd0 : ((&r_cnt) ? r_cnt : r_cnt + 4'd1);
    o_force   = r_cnt >= 4'(MAX_WAIT);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= 4'd0;
    else      r_cnt <= w_cnt_nxt;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port RAM sharing between CPU and loader, CPU priority with loader anti-starvation
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);
  logic   w_force;
  logic   w_cpu_gnt;
  logic   w_ldr_gnt;
  logic   w_rd;
  logic   r_rd_pend;
  logic   r_rd_tag_ldr;
  owner_e r_owner;

  ram_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.ldr_req),
    .i_gnt   (w_ldr_gnt),
    .o_force (w_force)
  );

  // reset gates every grant and rvalid so nothing leaks while rst is low
  always_comb begin
    w_ldr_gnt      = rst & bus.ldr_req & (~bus.cpu_req | w_force);
    w_cpu_gnt      = rst & bus.cpu_req & ~w_ldr_gnt;
    w_rd           = (w_cpu_gnt & ~bus.cpu_we) | (w_ldr_gnt & ~bus.ldr_we);
    bus.cpu_gnt    = w_cpu_gnt;
    bus.ldr_gnt    = w_ldr_gnt;
    bus.ram_we     = w_cpu_gnt ? bus.cpu_we    : (w_ldr_gnt ? bus.ldr_we    : 1'b0);
    bus.ram_addr   = w_cpu_gnt ? bus.cpu_addr  : (w_ldr_gnt ? bus.ldr_addr  : '0);
    bus.ram_din    = w_cpu_gnt ? bus.cpu_wdata : (w_ldr_gnt ? bus.ldr_wdata : '0);
    bus.cpu_rvalid = rst & r_rd_pend & ~r_rd_tag_ldr;
    bus.ldr_rvalid = rst & r_rd_pend & r_rd_tag_ldr;
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_dout : '0;
    bus.ldr_rdata  = bus.ldr_rvalid ? bus.ram_dout : '0;
    bus.owner      = r_owner;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OWNER_NONE;
      r_rd_pend    <= 1'b0;
      r_rd_tag_ldr <= 1'b0;
    end else begin
      r_owner      <= w_cpu_gnt ? OWNER_CPU : (w_ldr_gnt ? OWNER_LDR : r_owner);
      r_rd_pend    <= w_rd;
      r_rd_tag_ldr <= w_rd ? w_ldr_gnt : r_rd_tag_ldr;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed plus random traffic against a rule-level model of grants, RAM and read returns
module tb_ram_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;
  ram_arbiter_if bus ();
  ram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [15:0] mem [64];
  always @(posedge clk) begin
    bus.ram_dout <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] = bus.ram_din;
  end

  logic [15:0] exp_mem [64];
  int          m_wait;
  int          m_owner;
  bit          m_pend;
  bit          m_tag_ldr;
  logic [15:0] m_rdata;
  bit          last_cg;
  bit          last_lg;

  function automatic logic [15:0] init_val(input int i);
    return (i == 5) ? 16'h1234 : 16'(i * 257 + 16'h0F00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cpu_gnt"}, 32'(bus.cpu_gnt), 0);
    chk({tag, "_ldr_gnt"}, 32'(bus.ldr_gnt), 0);
    chk({tag, "_ram_we"}, 32'(bus.ram_we), 0);
    chk({tag, "_cpu_rvalid"}, 32'(bus.cpu_rvalid), 0);
    chk({tag, "_ldr_rvalid"}, 32'(bus.ldr_rvalid), 0);
    chk({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 0);
    chk({tag, "_ldr_rdata"}, 32'(bus.ldr_rdata), 0);
    chk({tag, "_owner"}, 32'(bus.owner), 0);
  endtask

  task automatic model_reset();
    m_wait = 0; m_owner = 0; m_pend = 0; m_tag_ldr = 0; last_cg = 0; last_lg = 0;
  endtask

  task automatic step(input bit cr, input bit cw, input logic [5:0] ca, input logic [15:0] cd,
                      input bit lr, input bit lw, input logic [5:0] la, input logic [15:0] ld);
    bit eg_c, eg_l;
    @(negedge clk);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.ldr_req = lr; bus.ldr_we = lw; bus.ldr_addr = la; bus.ldr_wdata = ld;
    #1;
    eg_l = lr && (!cr || m_wait >= MAX_WAIT);
    eg_c = cr && !eg_l;
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(eg_c));
    chk("ldr_gnt", 32'(bus.ldr_gnt), 32'(eg_l));
    chk("ram_we", 32'(bus.ram_we), 32'((eg_c && cw) || (eg_l && lw)));
    chk("ram_addr", 32'(bus.ram_addr), eg_c ? 32'(ca) : (eg_l ? 32'(la) : 0));
    chk("ram_din", 32'(bus.ram_din), eg_c ? 32'(cd) : (eg_l ? 32'(ld) : 0));
    @(posedge clk);
    #1;
    m_pend    = (eg_c && !cw) || (eg_l && !lw);
    m_tag_ldr = eg_l;
    m_rdata   = eg_c ? exp_mem[ca] : exp_mem[la];
    if (eg_c && cw) exp_mem[ca] = cd;
    if (eg_l && lw) exp_mem[la] = ld;
    m_wait  = (!lr || eg_l) ? 0 : ((m_wait >= 15) ? 15 : m_wait + 1);
    m_owner = eg_c ? 1 : (eg_l ? 2 : m_owner);
    last_cg = eg_c; last_lg = eg_l;
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_pend && !m_tag_ldr));
    chk("ldr_rvalid", 32'(bus.ldr_rvalid), 32'(m_pend && m_tag_ldr));
    chk("cpu_rdata", 32'(bus.cpu_rdata), (m_pend && !m_tag_ldr) ? 32'(m_rdata) : 0);
    chk("ldr_rdata", 32'(bus.ldr_rdata), (m_pend && m_tag_ldr) ? 32'(m_rdata) : 0);
    chk("owner", 32'(bus.owner), 32'(m_owner));
  endtask

  initial begin
    bit cr, cw, lr, lw;
    logic [5:0] ca, la;
    logic [15:0] cd, ld;
    for (int i = 0; i < 64; i++) begin
      mem[i] = init_val(i);
      exp_mem[i] = init_val(i);
    end
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    // CPU read of addr 5, then a loader write and CPU read-back
    step(1, 0, 6'd5, 16'h0, 0, 0, 6'd0, 16'h0);
    chk("t1_rdata_1234", 32'(bus.cpu_rdata), 32'h1234);
    step(0, 0, 6'd0, 16'h0, 1, 1, 6'd9, 16'hABCD);
    step(1, 0, 6'd9, 16'h0, 0, 0, 6'd0, 16'h0);
    chk("t2_rdata_abcd", 32'(bus.cpu_rdata), 32'hABCD);
    // continuous contention: four CPU grants then one forced loader grant
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 6'(i), 16'h0, 1, 0, 6'(40 + i), 16'h0);
      chk("t3_pattern", 32'(last_lg), 32'(i % 5 == 4));
    end
    step(0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0);
    // alternating reads: tags must never cross
    for (int i = 0; i < 6; i++)
      if (i % 2 == 0) step(1, 0, 6'd1, 16'h0, 0, 0, 6'd0, 16'h0);
      else            step(0, 0, 6'd0, 16'h0, 1, 0, 6'd2, 16'h0);
    // reset while a CPU read is in flight
    step(1, 0, 6'd7, 16'h0, 0, 0, 6'd0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    @(posedge clk);
    #1;
    chk_idle_outputs("rst_hold");
    @(negedge clk);
    bus.cpu_req = 0;
    rst = 1'b1;
    model_reset();
    #1;
    chk_idle_outputs("rst_rel");
    @(posedge clk);
    #1;
    chk_idle_outputs("rst_after");
    // loader waits two cycles, drops, re-requests: counter restarts from zero
    step(1, 1, 6'd20, 16'h1111, 1, 1, 6'd30, 16'h2222);
    step(1, 1, 6'd21, 16'h1112, 1, 1, 6'd30, 16'h2222);
    step(1, 1, 6'd22, 16'h1113, 0, 0, 6'd0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 6'(23 + i), 16'h1200, 1, 1, 6'd31, 16'h3333);
      chk("t6_ldr_latency", 32'(last_lg), 32'(i == 4));
    end
    // random traffic under the hold-until-grant rule, with occasional cancels
    cr = 0; lr = 0; cw = 0; lw = 0; ca = '0; la = '0; cd = '0; ld = '0;
    for (int i = 0; i < 120; i++) begin
      if (!cr || last_cg) begin
        cr = ($urandom_range(9) < 6); cw = 1'($urandom); ca = 6'($urandom); cd = 16'($urandom);
      end else if ($urandom_range(9) == 0) cr = 0;
      if (!lr || last_lg) begin
        lr = ($urandom_range(9) < 5); lw = 1'($urandom); la = 6'($urandom); ld = 16'($urandom);
      end else if ($urandom_range(19) == 0) lr = 0;
      step(cr, cw, ca, cd, lr, lw, la, ld);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
